// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and constants for the cache port arbiter
package cache_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/cache_port_arbiter_rr.sv
// rtl/cache_port_arbiter_rr.sv - two-way round-robin pick, purely combinational
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  // On contention the requester that was not granted last wins.
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares one cache CPU port between an instruction and a data requester
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rreq,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_hit,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rreq,
  input  logic              m1_wreq,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_hit,
  output logic [ADDR_W-1:0] addr_to_cache,
  output logic              rreq_to_cache,
  output logic              wreq_to_cache,
  output logic [DATA_W-1:0] wdata_to_cache,
  input  logic [DATA_W-1:0] rdata_from_cache,
  input  logic              hit_from_cache,
  output logic              err_timeout
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state;
  logic          gnt_id;
  logic          last;
  logic          dropped;
  logic [CW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic          live_req;
  logic          hit_ok;
  logic          timed_out;

  assign req = {m1_rreq | m1_wreq, m0_rreq};

  rr_arbiter2 u_rr (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  // A requester that let go of its request mid-grant gets no completion pulse.
  assign live_req  = (gnt_id == REQ_M1) ? req[1] : req[0];
  assign hit_ok    = (state == BUSY) & hit_from_cache & ~dropped & live_req;
  assign m0_hit    = hit_ok & (gnt_id == REQ_M0);
  assign m1_hit    = hit_ok & (gnt_id == REQ_M1);
  assign m0_rdata  = rdata_from_cache;
  assign m1_rdata  = rdata_from_cache;
  assign timed_out = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      gnt_id         <= REQ_M0;
      last           <= REQ_M1;
      dropped        <= 1'b0;
      cnt            <= '0;
      err_timeout    <= 1'b0;
      addr_to_cache  <= '0;
      wdata_to_cache <= '0;
      rreq_to_cache  <= 1'b0;
      wreq_to_cache  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cnt     <= '0;
            dropped <= 1'b0;
            state   <= BUSY;
            if (grant[REQ_M1]) begin
              gnt_id         <= REQ_M1;
              addr_to_cache  <= m1_addr;
              wdata_to_cache <= m1_wdata;
              wreq_to_cache  <= m1_wreq;
              rreq_to_cache  <= ~m1_wreq;
            end else begin
              gnt_id        <= REQ_M0;
              addr_to_cache <= m0_addr;
              rreq_to_cache <= 1'b1;
              wreq_to_cache <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (!live_req) dropped <= 1'b1;
          if (hit_from_cache) begin
            last          <= gnt_id;
            rreq_to_cache <= 1'b0;
            wreq_to_cache <= 1'b0;
            state         <= RELEASE;
          end else if (timed_out) begin
            err_timeout   <= 1'b1;
            rreq_to_cache <= 1'b0;
            wreq_to_cache <= 1'b0;
            state         <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
